// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared sound constants: pattern entry layout, sequencer states, envelope ROM layout
package sound_pkg;

  // Pattern entry layout: [15:12] instrument, [11:8] duration, [7:0] note
  localparam int ENTRY_INSTR_LSB = 12;
  localparam int ENTRY_INSTR_W   = 4;
  localparam int ENTRY_DUR_LSB   = 8;
  localparam int ENTRY_DUR_W     = 4;
  localparam int ENTRY_NOTE_LSB  = 0;
  localparam int ENTRY_NOTE_W    = 8;

  localparam logic [7:0] NOTE_REST    = 8'h00;
  localparam logic [3:0] DURATION_END = 4'h0;

  // Sequencer states; code 2'd3 is unused and recovers to SEQ_START
  typedef enum logic [1:0] {
    SEQ_START      = 2'd0,
    SEQ_FETCH_ADDR = 2'd1,
    SEQ_READ_DATA  = 2'd2
  } seq_state_t;

  // Envelope generator ROM layout (instrument tables share the ROM with patterns)
  localparam logic [7:0] ENV_ROM_BASE        = 8'h00;
  localparam logic [7:0] ENV_WORDS_PER_INSTR = 8'h04;

  function automatic logic [3:0] entry_instrument(input logic [15:0] entry);
    return entry[ENTRY_INSTR_LSB +: ENTRY_INSTR_W];
  endfunction

  function automatic logic [3:0] entry_duration(input logic [15:0] entry);
    return entry[ENTRY_DUR_LSB +: ENTRY_DUR_W];
  endfunction

  function automatic logic [7:0] entry_note(input logic [15:0] entry);
    return entry[ENTRY_NOTE_LSB +: ENTRY_NOTE_W];
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - pattern ROM bus and voice outputs of the note sequencer
interface note_sequencer_if;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        strobe;
  logic        load_instrument;
  logic [3:0]  instrument;
  logic [7:0]  note;
  logic        gate;

  modport master (
    output rom_addr,
    input  rom_data,
    output strobe,
    output load_instrument,
    output instrument,
    output note,
    output gate
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  strobe,
    input  load_instrument,
    input  instrument,
    input  note,
    input  gate
  );
endinterface

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - frame-driven pattern sequencer feeding envelope and oscillator; optional NOTE_SEQUENCER_TRANSPOSE_EN
module note_sequencer
  import sound_pkg::*;
#(
  parameter logic [7:0] BASE_ADDRESS   = 8'h40,
  parameter int         PATTERN_LENGTH = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_enable,
  input  logic                              i_frame_tick,
  input  logic                              i_restart,
`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
  input  logic signed [3:0]                 i_transpose,
`endif
  output logic [$clog2(PATTERN_LENGTH)-1:0] o_row_index,
  note_sequencer_if.master                  bus
);

  localparam int ROW_W = $clog2(PATTERN_LENGTH);

  seq_state_t       r_state;
  logic [ROW_W-1:0] r_row;
  logic [3:0]       r_remaining;
  logic             r_strobe;
  logic             r_load;
  logic [3:0]       r_instrument;
  logic [7:0]       r_note;
  logic             r_gate;

  seq_state_t       w_nxt_state;
  logic [ROW_W-1:0] w_nxt_row;
  logic [3:0]       w_nxt_remaining;
  logic             w_nxt_strobe;
  logic             w_nxt_load;
  logic [3:0]       w_nxt_instrument;
  logic [7:0]       w_nxt_note;
  logic             w_nxt_gate;
  logic [7:0]       w_rom_addr;

  logic [3:0]       w_entry_instr;
  logic [3:0]       w_entry_dur;
  logic [7:0]       w_entry_note;
  logic [7:0]       w_note_adj;

  assign w_entry_instr = entry_instrument(bus.rom_data);
  assign w_entry_dur   = entry_duration(bus.rom_data);
  assign w_entry_note  = entry_note(bus.rom_data);

`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
  logic signed [9:0] w_note_sum;
  assign w_note_sum = $signed({2'b00, w_entry_note}) + $signed({{6{i_transpose[3]}}, i_transpose});

  // Transposed pitch, clamped so a real note never collapses into a rest
  always_comb begin
    w_note_adj = w_entry_note;
    if (w_entry_note != NOTE_REST) begin
      if (w_note_sum < 10'sd1)        w_note_adj = 8'd1;
      else if (w_note_sum > 10'sd255) w_note_adj = 8'hFF;
      else                            w_note_adj = w_note_sum[7:0];
    end
  end
`else
  assign w_note_adj = w_entry_note;
`endif

  // State register plus all datapath registers, async-cleared
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= SEQ_START;
      r_row        <= '0;
      r_remaining  <= 4'd0;
      r_strobe     <= 1'b0;
      r_load       <= 1'b0;
      r_instrument <= 4'd0;
      r_note       <= 8'd0;
      r_gate       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_row        <= w_nxt_row;
      r_remaining  <= w_nxt_remaining;
      r_strobe     <= w_nxt_strobe;
      r_load       <= w_nxt_load;
      r_instrument <= w_nxt_instrument;
      r_note       <= w_nxt_note;
      r_gate       <= w_nxt_gate;
    end
  end

  // Next-state, datapath updates and ROM address; restart overrides everything
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_row        = r_row;
    w_nxt_remaining  = r_remaining;
    w_nxt_strobe     = 1'b0;
    w_nxt_load       = 1'b0;
    w_nxt_instrument = r_instrument;
    w_nxt_note       = r_note;
    w_nxt_gate       = r_gate;
    w_rom_addr       = 8'h00;

    case (r_state)
      SEQ_START: begin
        if (i_frame_tick && i_enable) begin
          if (r_remaining != 4'd0) begin
            w_nxt_remaining = r_remaining - 4'd1;
            w_nxt_strobe    = 1'b1;
          end else begin
            w_nxt_state = SEQ_FETCH_ADDR;
          end
        end
      end
      SEQ_FETCH_ADDR: begin
        w_rom_addr  = BASE_ADDRESS + 8'(r_row);
        w_nxt_state = SEQ_READ_DATA;
      end
      SEQ_READ_DATA: begin
        if (w_entry_dur != DURATION_END) begin
          w_nxt_note      = w_note_adj;
          // A rest leaves the instrument alone so the envelope keeps its voice
          if (w_entry_note != NOTE_REST) w_nxt_instrument = w_entry_instr;
          w_nxt_gate      = (w_entry_note != NOTE_REST);
          w_nxt_load      = (w_entry_note != NOTE_REST);
          w_nxt_strobe    = 1'b1;
          w_nxt_remaining = w_entry_dur - 4'd1;
          w_nxt_row       = r_row + ROW_W'(1);
          w_nxt_state     = SEQ_START;
        end else if (r_row != '0) begin
          w_nxt_row   = '0;
          w_nxt_state = SEQ_FETCH_ADDR;
        end else begin
          // End marker at row 0: the pattern is empty, stay silent
          w_nxt_gate      = 1'b0;
          w_nxt_remaining = 4'd0;
          w_nxt_state     = SEQ_START;
        end
      end
      default: w_nxt_state = SEQ_START;
    endcase

    if (i_restart) begin
      w_nxt_state     = SEQ_START;
      w_nxt_row       = '0;
      w_nxt_remaining = 4'd0;
      w_nxt_gate      = 1'b0;
      w_nxt_strobe    = 1'b0;
      w_nxt_load      = 1'b0;
    end
  end

  assign bus.rom_addr        = w_rom_addr;
  assign bus.strobe          = r_strobe;
  assign bus.load_instrument = r_load;
  assign bus.instrument      = r_instrument;
  assign bus.note            = r_note;
  assign bus.gate            = r_gate;
  assign o_row_index         = r_row;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - randomized scoreboard bench for note_sequencer
module tb_note_sequencer;

  localparam logic [7:0] BASE = 8'h40;
  localparam int         PL   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] row_index;

  note_sequencer_if bus();

  logic [15:0] rom_mem [0:255];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic       load;
    logic [3:0] instr;
    logic [7:0] note;
    logic       gate;
    int         row;
  } strobe_t;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
  } addr_t;

  strobe_t exp_strobe[$];
  addr_t   exp_addr[$];

  // Reference model of the sequencer's visible state
  int         m_row = 0;
  int         m_rem = 0;
  logic [3:0] m_instr = 4'd0;
  logic [7:0] m_note = 8'd0;
  logic       m_gate = 1'b0;

  note_sequencer #(.BASE_ADDRESS(BASE), .PATTERN_LENGTH(PL)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_frame_tick (tick),
    .i_restart    (restart),
`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
    .i_transpose  (4'sd0),
`endif
    .o_row_index  (row_index),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: word appears the cycle after its address
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops scoreboard entries whenever the DUT strobes or fetches
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.strobe === 1'b1) begin
        if (exp_strobe.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          strobe_t s;
          s = exp_strobe.pop_front();
          check("strobe_cycle", cyc, s.cyc);
          check("strobe_load", bus.load_instrument, s.load);
          check("strobe_instrument", bus.instrument, s.instr);
          check("strobe_note", bus.note, s.note);
          check("strobe_gate", bus.gate, s.gate);
          check("strobe_row_index", row_index, s.row);
        end
      end else if (bus.load_instrument !== 1'b0) begin
        check("load_without_strobe", bus.load_instrument, 0);
      end
      if (bus.rom_addr !== 8'h00) begin
        if (exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_fetch actual=%0h expected=none (cycle %0d)", bus.rom_addr, cyc);
        end else begin
          addr_t a;
          a = exp_addr.pop_front();
          check("fetch_cycle", cyc, a.cyc);
          check("fetch_addr", bus.rom_addr, a.addr);
        end
      end
    end
  end

  function automatic logic [7:0] row_addr(input int row);
    logic [7:0] a;
    a = BASE + 8'(row);
    return a;
  endfunction

  // Expected consequences of one accepted tick issued in cycle t0
  task automatic model_tick(input int t0, input bit restart_read);
    logic [15:0] e;
    int lat;
    if (m_rem != 0) begin
      m_rem--;
      exp_strobe.push_back('{t0 + 1, 1'b0, m_instr, m_note, m_gate, m_row});
    end else begin
      exp_addr.push_back('{t0 + 1, row_addr(m_row)});
      if (!restart_read) begin
        e = rom_mem[row_addr(m_row)];
        lat = 3;
        if (e[11:8] == 4'd0 && m_row != 0) begin
          m_row = 0;
          exp_addr.push_back('{t0 + 3, row_addr(0)});
          e = rom_mem[row_addr(0)];
          lat = 5;
        end
        if (e[11:8] == 4'd0) begin
          m_gate = 1'b0;
          m_rem = 0;
        end else begin
          m_note = e[7:0];
          if (e[7:0] != 8'd0) m_instr = e[15:12];
          m_gate = (e[7:0] != 8'd0);
          m_rem = int'(e[11:8]) - 1;
          m_row = (m_row + 1) % PL;
          exp_strobe.push_back('{t0 + lat, m_gate, m_instr, m_note, m_gate, m_row});
        end
      end
    end
    if (restart_read) begin
      m_row = 0;
      m_rem = 0;
      m_gate = 1'b0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input bit en, input bit drop_en, input bit restart_read);
    int t0;
    int used;
    enable = en;
    tick = 1'b1;
    t0 = cyc;
    if (en) model_tick(t0, restart_read);
    step(1);
    tick = 1'b0;
    if (drop_en) enable = 1'b0;
    used = 1;
    if (restart_read) begin
      step(1);
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      used = 3;
    end
    step($urandom_range(9, 12) - used);
    enable = 1'b1;
  endtask

  task automatic restart_idle();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    m_row = 0;
    m_rem = 0;
    m_gate = 1'b0;
    step(8);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_strobe"}, bus.strobe, 0);
    check({tag, "_load"}, bus.load_instrument, 0);
    check({tag, "_instrument"}, bus.instrument, 0);
    check({tag, "_note"}, bus.note, 0);
    check({tag, "_gate"}, bus.gate, 0);
    check({tag, "_row_index"}, row_index, 0);
    check({tag, "_rom_addr"}, bus.rom_addr, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'h0000;
    step(3);
    check_cleared("reset");
    rst_n = 1'b1;
    step(4);

    // Directed: note, countdown, rest, end marker refetch
    rom_mem[8'h40] = 16'h3245;
    rom_mem[8'h41] = 16'h5100;
    rom_mem[8'h42] = 16'h0000;
    for (int i = 0; i < 4; i++) do_tick(1'b1, 1'b0, 1'b0);
    check("end_marker_row_index", row_index, m_row);

    // Empty pattern: row 0 is an end marker
    rom_mem[8'h40] = 16'h0000;
    restart_idle();
    do_tick(1'b1, 1'b0, 1'b0);
    check("empty_gate", bus.gate, 0);

    // Full wrap: every row lasts one frame
    for (int r = 0; r < PL; r++)
      rom_mem[row_addr(r)] = {4'($urandom_range(0, 15)), 4'h1, 8'($urandom_range(1, 255))};
    restart_idle();
    for (int i = 0; i < PL; i++) do_tick(1'b1, 1'b0, 1'b0);
    check("wrap_row_index", row_index, 0);
    do_tick(1'b1, 1'b0, 1'b0);

    // Restart while the ROM word is being read
    do_tick(1'b1, 1'b0, 1'b1);
    check("restart_gate", bus.gate, 0);
    check("restart_row_index", row_index, 0);
    do_tick(1'b1, 1'b0, 1'b0);

    // Randomized patterns with enable gaps, mid-fetch enable drops and idle restarts
    for (int r = 0; r < PL; r++) begin
      logic [3:0] d;
      d = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
      rom_mem[row_addr(r)] = {4'($urandom_range(0, 15)), d,
                              ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255))};
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) restart_idle();
      do_tick($urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, 1'b0);
    end

    // Async reset asserted during FETCH_ADDR
    rom_mem[8'h40] = 16'h7312;
    restart_idle();
    enable = 1'b1;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    rst_n = 1'b0;
    #1;
    check_cleared("async_reset");
    m_row = 0;
    m_rem = 0;
    m_gate = 1'b0;
    m_note = 8'd0;
    m_instr = 4'd0;
    step(2);
    rst_n = 1'b1;
    step(2);
    do_tick(1'b1, 1'b0, 1'b0);

    step(12);
    check("pending_strobes", exp_strobe.size(), 0);
    check("pending_fetches", exp_addr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream driver of the per-channel envelope generator.
- On each frame tick it either counts down the current note's duration or fetches the next pattern entry from the shared 8-bit-address / 16-bit-data ROM.
- It emits one strobe per frame, with a load-instrument flag and instrument number aligned to that strobe.
- It also presents note pitch and gate to the channel oscillator.

Parameters:
- BASE_ADDRESS, 8'h40: ROM word address of pattern row 0.
- PATTERN_LENGTH, 16: number of rows; power of two, 2..64; row index wraps at this value.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  run enable; ticks are ignored while low.
- i_frame_tick  input  1  single-cycle frame pulse, at least 8 cycles apart.
- i_restart  input  1  single-cycle pulse: rewind to row 0.
- o_strobe  output  1  one-cycle pulse per accepted frame; drives the envelope generator's i_strobe.
- o_load_instrument  output  1  high only during an o_strobe cycle that starts a new note.
- o_instrument  output  4  instrument of the current note; held between notes.
- o_note  output  8  current pitch index; 0 = rest.
- o_gate  output  1  high while a non-rest note is active.
- o_row_index  output  $clog2(PATTERN_LENGTH)  row that will be fetched next.
- o_rom_addr  output  8  ROM address; combinational, 0 when not fetching.
- i_rom_data  input  16  ROM word, valid the cycle after the address is driven.

Behaviour:
- Entry format: [15:12] instrument, [11:8] duration in frames, [7:0] note.
- A duration of 0 marks end of pattern; that entry's note and instrument fields are ignored.
- Async reset (i_rst_n low): all registers and outputs 0, state START, remaining=0, row_index=0.
- States: START, FETCH_ADDR, READ_DATA. Encoding 2 bits; unused code goes to START.
- START:
  - Waits for i_frame_tick & i_enable.
  - If remaining!=0: remaining-1 and o_strobe=1 next cycle, with o_load_instrument=0. Latency 1 cycle.
  - If remaining==0: go to FETCH_ADDR.
- FETCH_ADDR: o_rom_addr = BASE_ADDRESS + row_index, 8-bit wrap. Go to READ_DATA.
- READ_DATA, duration!=0:
  - Latch o_note and o_instrument; remaining = duration-1.
  - row_index+1 modulo PATTERN_LENGTH.
  - Register o_strobe=1, o_load_instrument=(note!=0), o_gate=(note!=0). Go to START.
  - Tick-to-strobe latency 3 cycles.
  - A rest keeps the previous o_instrument, clears o_gate, and still strobes so the envelope keeps advancing.
- READ_DATA, duration==0:
  - If row_index!=0: row_index=0 and go to FETCH_ADDR (latency 5 cycles).
  - If row_index==0 (empty pattern): no strobe, o_gate=0, remaining=0, go to START.
- o_strobe and o_load_instrument are registered single-cycle pulses, cleared the following cycle.
- Ticks arriving in FETCH_ADDR or READ_DATA are dropped.
- i_enable falling mid-fetch: the fetch completes and its strobe is issued.
- i_restart, accepted in any state:
  - Next cycle: state START, row_index=0, remaining=0, o_gate=0.
  - Any pending strobe is suppressed; o_note and o_instrument are held.
  - A restart coinciding with a tick wins, and the tick is lost.
- Row advance at PATTERN_LENGTH-1 wraps to 0 with no end marker required.

Optional Feature:
- NOTE_SEQUENCER_TRANSPOSE_EN.
- Defined:
  - Adds input i_transpose (4-bit signed, -8..+7).
  - A non-rest note latched in READ_DATA becomes note+i_transpose, saturated to 1..255. Rests stay 0.
  - i_transpose is sampled only in READ_DATA.
- Undefined: port absent; note passes unchanged.

Decomposition:
- Shared package sound_pkg holds:
  - pattern entry field positions and widths (instrument, duration, note)
  - NOTE_REST = 8'h00
  - DURATION_END = 4'h0
  - sequencer state localparams
- The envelope generator's ROM layout constants also move to sound_pkg.
- No sub-module: decode is a few bit slices and the block stays single-module.

Test Plan:
- Reset, then row0=16'h3_2_45, tick -> o_rom_addr=8'h40 at T+1; at T+3 o_strobe=1, o_load_instrument=1, o_instrument=3, o_note=8'h45, o_gate=1.
- Following tick -> o_strobe at T+1, o_load_instrument=0. The next tick fetches row1 (address 8'h41).
- Row1=16'h5_1_00 (rest) -> strobe at T+3, o_load_instrument=0, o_gate=0, o_instrument stays 3.
- Row2=16'h0_0_00 (end marker) -> refetch at 8'h40, strobe at T+5, row_index=1 afterwards. With row0 also an end marker: no strobe, o_gate=0.
- Filling all 16 rows with duration 1 and issuing 17 ticks -> addresses 8'h40..8'h4F, then 8'h40; row_index wraps to 0.
- i_restart during READ_DATA -> no strobe; next tick fetches 8'h40. Async reset asserted mid-fetch -> all outputs 0 immediately.
